sequence_detect_param: RTL



---
 rtl/sequence_detect_pkg.sv | 22 ++
 rtl/sequence_detect_param_sat_counter.sv | 27 ++
 rtl/sequence_detect_param.sv | 102 ++++++++++
 3 files changed

// File: rtl/sequence_detect_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   SD_MODE_NONOVL / SD_MODE_OVL : values of the overlap configuration bit
//   SD_MAX_W                     : widest pattern the compare helper accepts
//   sd_window_hit()              : masked compare of a candidate window
package sequence_detect_pkg;

    localparam logic SD_MODE_NONOVL = 1'b0;
    localparam logic SD_MODE_OVL    = 1'b1;

    localparam int SD_MAX_W = 32;

    // Callers zero-extend narrower windows. The unused upper bits are zero
    // in the mask, so they never affect the result.
    function automatic logic sd_window_hit(
        input logic [SD_MAX_W-1:0] cand,
        input logic [SD_MAX_W-1:0] pat,
        input logic [SD_MAX_W-1:0] mask
    );
        return ((cand ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/sequence_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, count goes to 0
//   clr   : clear count to 0, wins over inc
//   inc   : add one, holds at all ones
//   cnt   : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sequence_detect_param.sv
// Parametrised serial pattern detector with runtime pattern/mask, overlap
// mode, window-fill qualification and a saturating match counter.
//   clk, rst_n          : clock, synchronous active-low reset
//   data, data_valid    : gated serial bit stream
//   cfg_load            : capture cfg_* and clear the history
//   cfg_pattern         : pattern, bit [PATTERN_W-1] is the oldest bit
//   cfg_mask            : 1 = compare bit, 0 = don't care
//   cfg_overlap         : 1 = overlapping, 0 = non-overlapping detection
//   clr_cnt             : clear match_cnt (wins over a coincident hit)
//   match               : one-cycle pulse, cycle after the completing bit
//   match_cnt           : saturating count of matches
//   window_full         : a full window of valid bits is held
module sequence_detect_param
    import sequence_detect_pkg::*;
#(
    parameter int                   PATTERN_W       = 4,
    parameter int                   CNT_W           = 8,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(4'b0110),
    parameter logic [PATTERN_W-1:0] DEFAULT_MASK    = '1,
    parameter logic                 DEFAULT_OVERLAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data,
    input  logic                 data_valid,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic [PATTERN_W-1:0] cfg_mask,
    input  logic                 cfg_overlap,
    input  logic                 clr_cnt,
    output logic                 match,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 window_full
);

    localparam int                FILL_W   = $clog2(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);

    logic [PATTERN_W-1:0] pat_q;
    logic [PATTERN_W-1:0] mask_q;
    logic                 overlap_q;
    logic [PATTERN_W-2:0] hist;
    logic [FILL_W-1:0]    fill;

    logic [PATTERN_W-1:0] cand;
    logic                 fill_ok;
    logic                 hit;

    assign cand    = {hist, data};
    assign fill_ok = (fill == FILL_MAX);

    // A bit arriving together with cfg_load is discarded, so it must not
    // reach the counter either.
    assign hit = data_valid & ~cfg_load & fill_ok &
                 sd_window_hit(SD_MAX_W'(cand), SD_MAX_W'(pat_q), SD_MAX_W'(mask_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q       <= DEFAULT_PATTERN;
            mask_q      <= DEFAULT_MASK;
            overlap_q   <= DEFAULT_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            window_full <= 1'b0;
        end else if (cfg_load) begin
            pat_q       <= cfg_pattern;
            mask_q      <= cfg_mask;
            overlap_q   <= cfg_overlap;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            window_full <= 1'b0;
        end else begin
            match <= hit;
            if (data_valid) begin
                // Low bits of the candidate form the next history; this
                // also covers PATTERN_W == 2 where hist is a single bit.
                hist <= cand[PATTERN_W-2:0];
                if (hit && (overlap_q == SD_MODE_NONOVL)) begin
                    fill        <= '0;
                    window_full <= 1'b0;
                end else if (fill_ok) begin
                    window_full <= 1'b1;
                end else begin
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (hit),
        .cnt   (match_cnt)
    );

endmodule
